kgp_multicycle_ctrl: RTL and testbench
======================================

// Module: kgp_multicycle_ctrl
// PURPOSE
//  Parametrised multi-cycle control FSM for the KGP-RISC datapath.
//  Sequences every instruction through explicit IF/ID/EX/MEM/WB states with registered control outputs.
//  Adds a data-memory ready handshake with a timeout, and illegal-opcode handling.
//  Sits between the instruction register (irout) and all datapath load/select/enable strobes.
// PARAMETERS
//  IW          32  instruction width; class = irout[IW-1 -:2], opcode = irout[IW-1 -:OPW]
//  OPW         6   opcode field width
//  FW          6   R-type funct field width, irout[FW-1:0]
//  AFW         4   alufunc width
//  MEM_TIMEOUT 15  max MEM wait cycles before abort (>=1)
// PORTS
//  clk        in   1    clock, rising edge
//  reset      in   1    synchronous, active-high reset
//  irout      in   IW   current instruction register contents
//  dmem_ready in   1    data memory has completed the access this cycle
//  readim,ldir,ldnpc               out 1 fetch strobes
//  ldA,ldB,ldimm                   out 1 decode/operand latch strobes
//  cond_sel   out  2    branch condition: 00 PL, 01 MI, 10 Z, 11 always
//  opcond,alusel1,alusel2,aluen,ldaluout out 1 execute strobes
//  alufunc    out  AFW  ALU op: 0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOT,6 SLA,7 SLL,8 SRA,9 SRL,10 PASS
//  writedmem,readdmem,ldlmd        out 1 memory strobes
//  selwb,regwrite,branch,ldpc      out 1 write-back/PC strobes
//  mem_err    out  1    one-cycle pulse on MEM timeout
//  illegal    out  1    sticky illegal-opcode flag (only with KGP_CTRL_ILLEGAL_TRAP_EN)
// BEHAVIOUR
//  - reset=1 at an edge: state<=S_RST, every output <=0, wait counter <=0, illegal <=0; overrides any state, incl. mid-MEM.
//  - All outputs are registered: they reflect the state entered at the same edge.
//  - S_RST->S_IF unconditionally. IF: readim,ldir,ldnpc=1. ->S_ID.
//  - S_ID: ldA,ldB,ldimm=1; irout decoded and latched into an internal decode register. ->S_EX.
//  - S_EX: aluen,ldaluout=1; alufunc from decode. R: alusel1=1,alusel2=0. I/LD/ST: alusel1=1,alusel2=1.
//    Branch: opcond=1, alusel1=0, alusel2=1, alufunc=10. ->S_MEM for LD/ST, else ->S_WB.
//  - S_MEM: LD holds readdmem=1; ST holds writedmem=1. Both are held every cycle until dmem_ready=1.
//    dmem_ready=1 ends the access: LD pulses ldlmd at the next edge; ->S_WB. The wait counter clears on MEM entry.
//    Counter reaching MEM_TIMEOUT with dmem_ready=0: mem_err=1 for one cycle, strobes drop, ->S_WB with regwrite=0.
//  - S_WB: ldpc=1. R/I: regwrite=1, selwb=0. LD (no timeout): regwrite=1, selwb=1. ST/branch: regwrite=0.
//    Branch: branch=1, cond_sel from decode (BR=11, BMI=01, BPL=00, BZ=10). ->S_IF.
//  - Latency: R/I/branch 4 cycles IF..WB. LD/ST take 5 cycles plus N wait cycles (N<=MEM_TIMEOUT).
//  - Decode: class 00 = R, funct 1..10 -> alufunc 0..9. Class 01 opcodes 0x10..0x19 -> alufunc 0..9; 0x1A MOVE -> 0.
//    0x21 LD, 0x22 ST (alufunc 0), 0x30 BR, 0x31 BMI, 0x32 BPL, 0x33 BZ. Anything else is illegal.
//  - Illegal instruction without the macro: executes as NOP through IF,ID,EX,WB with only ldpc=1 in WB.
// CONFIGURATION
//  KGP_CTRL_ILLEGAL_TRAP_EN defined:
//    an illegal opcode in S_ID goes ->S_HALT; all outputs stay 0 and illegal=1 until reset.
//  Undefined: no S_HALT state; illegal port tied 0; NOP behaviour as above.
// STRUCTURE
//  Package kgp_ctrl_pkg: state encoding (S_RST,S_IF,S_ID,S_EX,S_MEM,S_WB,S_HALT), instr class enum,
//    opcode/funct constants, alufunc constants, cond_sel constants.
//  Sub-module kgp_instr_decode: combinational irout -> {class, alufunc, cond_sel, is_ld, is_st, is_br, illegal}.
// TESTING
//  1 reset held 3 cycles then ADD (class 00, funct 1) -> all outputs 0 during reset;
//    IF,ID,EX(alufunc=0),WB(regwrite=1,ldpc=1) in 4 cycles.
//  2 ADDI opcode 0x10 then SRLI 0x19 -> alusel2=1 in EX, alufunc 0 then 9; regwrite=1, selwb=0.
//  3 LD, dmem_ready low 3 cycles then high -> readdmem held 4 cycles, ldlmd pulse, WB selwb=1; total 8 cycles.
//  4 ST with dmem_ready stuck 0 -> writedmem high 15 cycles, mem_err one pulse, WB with regwrite=0.
//  5 BZ 0x33 -> EX opcond=1, alufunc=10; WB branch=1, cond_sel=10, ldpc=1, regwrite=0.
//  6 opcode 0x3F: NOP path without the macro; with KGP_CTRL_ILLEGAL_TRAP_EN -> S_HALT, illegal=1;
//    reset mid-MEM/HALT returns to S_RST.

Source files
------------

// File: rtl/kgp_ctrl_pkg.sv
// Shared types and constants for the KGP-RISC multi-cycle controller:
// state encoding, instruction classes, opcode/funct values, ALU codes, branch conditions.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    S_RST  = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_HALT = 3'd6
  } state_t;

  // Enum values match the two class bits at the top of the opcode.
  typedef enum logic [1:0] {
    CLS_R   = 2'b00,
    CLS_I   = 2'b01,
    CLS_MEM = 2'b10,
    CLS_BR  = 2'b11
  } instr_class_t;

  localparam int FUNCT_MIN = 1;
  localparam int FUNCT_MAX = 10;

  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_SRLI = 6'h19;
  localparam logic [5:0] OP_MOVE = 6'h1A;
  localparam logic [5:0] OP_LD   = 6'h21;
  localparam logic [5:0] OP_ST   = 6'h22;
  localparam logic [5:0] OP_BR   = 6'h30;
  localparam logic [5:0] OP_BMI  = 6'h31;
  localparam logic [5:0] OP_BPL  = 6'h32;
  localparam logic [5:0] OP_BZ   = 6'h33;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_PASS = 4'd10;

  localparam logic [1:0] COND_PL = 2'b00;
  localparam logic [1:0] COND_MI = 2'b01;
  localparam logic [1:0] COND_Z  = 2'b10;
  localparam logic [1:0] COND_AL = 2'b11;

  // All single-bit strobes plus cond_sel; alufunc stays separate since its width is a parameter.
  typedef struct packed {
    logic       readim;
    logic       ldir;
    logic       ldnpc;
    logic       lda;
    logic       ldb;
    logic       ldimm;
    logic [1:0] cond_sel;
    logic       opcond;
    logic       alusel1;
    logic       alusel2;
    logic       aluen;
    logic       ldaluout;
    logic       writedmem;
    logic       readdmem;
    logic       ldlmd;
    logic       selwb;
    logic       regwrite;
    logic       branch;
    logic       ldpc;
    logic       mem_err;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/kgp_instr_decode.sv
// Combinational instruction decoder: irout -> class, ALU function, branch condition,
// load/store/branch flags and an illegal-encoding flag.
module kgp_instr_decode
  import kgp_ctrl_pkg::*;
#(
  parameter int IW  = 32,
  parameter int OPW = 6,
  parameter int FW  = 6,
  parameter int AFW = 4
) (
  input  logic [IW-1:0]  irout,
  output instr_class_t   cls,
  output logic [AFW-1:0] alufunc,
  output logic [1:0]     cond_sel,
  output logic           is_ld,
  output logic           is_st,
  output logic           is_br,
  output logic           illegal
);

  logic [OPW-1:0] opcode;
  logic [FW-1:0]  funct;
  logic           unused_ir;

  assign opcode    = irout[IW-1 -: OPW];
  assign funct     = irout[FW-1:0];
  assign cls       = instr_class_t'(irout[IW-1 -: 2]);
  assign unused_ir = ^irout;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    alufunc  = AFW'(ALU_ADD);
    cond_sel = COND_PL;
    is_ld    = 1'b0;
    is_st    = 1'b0;
    is_br    = 1'b0;
    illegal  = 1'b0;
    case (cls)
      CLS_R: begin
        if (funct >= FW'(FUNCT_MIN) && funct <= FW'(FUNCT_MAX))
          alufunc = AFW'(funct - FW'(1));
        else
          illegal = 1'b1;
      end
      CLS_I: begin
        if (opcode >= OPW'(OP_ADDI) && opcode <= OPW'(OP_SRLI))
          alufunc = AFW'(opcode - OPW'(OP_ADDI));
        else if (opcode != OPW'(OP_MOVE))
          illegal = 1'b1;
      end
      CLS_MEM: begin
        if (opcode == OPW'(OP_LD))      is_ld   = 1'b1;
        else if (opcode == OPW'(OP_ST)) is_st   = 1'b1;
        else                            illegal = 1'b1;
      end
      CLS_BR: begin
        alufunc = AFW'(ALU_PASS);
        is_br   = 1'b1;
        if (opcode == OPW'(OP_BR))       cond_sel = COND_AL;
        else if (opcode == OPW'(OP_BMI)) cond_sel = COND_MI;
        else if (opcode == OPW'(OP_BPL)) cond_sel = COND_PL;
        else if (opcode == OPW'(OP_BZ))  cond_sel = COND_Z;
        else begin
          is_br   = 1'b0;
          illegal = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/kgp_multicycle_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control FSM for the KGP-RISC datapath with registered strobes.
// Optional macro KGP_CTRL_ILLEGAL_TRAP_EN: illegal opcodes enter S_HALT and set a sticky illegal flag.
module kgp_multicycle_ctrl
  import kgp_ctrl_pkg::*;
#(
  parameter int IW          = 32,
  parameter int OPW         = 6,
  parameter int FW          = 6,
  parameter int AFW         = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [IW-1:0]  irout,
  input  logic           dmem_ready,
  output logic           readim,
  output logic           ldir,
  output logic           ldnpc,
  output logic           ldA,
  output logic           ldB,
  output logic           ldimm,
  output logic [1:0]     cond_sel,
  output logic           opcond,
  output logic           alusel1,
  output logic           alusel2,
  output logic           aluen,
  output logic           ldaluout,
  output logic [AFW-1:0] alufunc,
  output logic           writedmem,
  output logic           readdmem,
  output logic           ldlmd,
  output logic           selwb,
  output logic           regwrite,
  output logic           branch,
  output logic           ldpc,
  output logic           mem_err,
  output logic           illegal
);

  localparam int WCW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t         state_q, state_d;
  ctrl_t          ctrl_q, ctrl_d;
  logic [AFW-1:0] alufunc_q, alufunc_d;
  logic [WCW-1:0] wait_q, wait_d;
  logic           timeout;

  instr_class_t   dec_cls;
  logic [AFW-1:0] dec_alufunc;
  logic [1:0]     dec_cond;
  logic           dec_ld, dec_st, dec_br, dec_illegal;

  // Decode register: captured while in S_ID, consumed by MEM and WB.
  logic           ld_q, st_q, br_q, nop_q;
  logic [1:0]     cond_q;

  kgp_instr_decode #(
    .IW  (IW),
    .OPW (OPW),
    .FW  (FW),
    .AFW (AFW)
  ) u_decode (
    .irout    (irout),
    .cls      (dec_cls),
    .alufunc  (dec_alufunc),
    .cond_sel (dec_cond),
    .is_ld    (dec_ld),
    .is_st    (dec_st),
    .is_br    (dec_br),
    .illegal  (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    ctrl_d    = CTRL_IDLE;
    alufunc_d = '0;
    timeout   = 1'b0;

    unique case (state_q)
      S_RST: state_d = S_IF;
      S_IF:  state_d = S_ID;
      S_ID: begin
`ifdef KGP_CTRL_ILLEGAL_TRAP_EN
        state_d = dec_illegal ? S_HALT : S_EX;
`else
        state_d = S_EX;
`endif
      end
      S_EX:  state_d = (ld_q || st_q) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_WB;
        end else if (wait_q == WCW'(MEM_TIMEOUT - 1)) begin
          state_d = S_WB;
          timeout = 1'b1;
        end
      end
      S_WB:  state_d = S_IF;
`ifdef KGP_CTRL_ILLEGAL_TRAP_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_RST;
    endcase

    // Outputs are those of the state being entered, so they decode from state_d.
    case (state_d)
      S_IF: begin
        ctrl_d.readim = 1'b1;
        ctrl_d.ldir   = 1'b1;
        ctrl_d.ldnpc  = 1'b1;
      end
      S_ID: begin
        ctrl_d.lda   = 1'b1;
        ctrl_d.ldb   = 1'b1;
        ctrl_d.ldimm = 1'b1;
      end
      S_EX: begin
        if (!dec_illegal) begin
          ctrl_d.aluen    = 1'b1;
          ctrl_d.ldaluout = 1'b1;
          alufunc_d       = dec_alufunc;
          if (dec_br) begin
            ctrl_d.opcond  = 1'b1;
            ctrl_d.alusel2 = 1'b1;
          end else begin
            ctrl_d.alusel1 = 1'b1;
            ctrl_d.alusel2 = (dec_cls != CLS_R);
          end
        end
      end
      S_MEM: begin
        ctrl_d.readdmem  = ld_q;
        ctrl_d.writedmem = st_q;
      end
      S_WB: begin
        ctrl_d.ldpc    = 1'b1;
        ctrl_d.mem_err = timeout;
        if (!timeout && !nop_q) begin
          if (br_q) begin
            ctrl_d.branch   = 1'b1;
            ctrl_d.cond_sel = cond_q;
          end else if (ld_q) begin
            ctrl_d.regwrite = 1'b1;
            ctrl_d.selwb    = 1'b1;
            ctrl_d.ldlmd    = 1'b1;
          end else if (!st_q) begin
            ctrl_d.regwrite = 1'b1;
          end
        end
      end
      default: ;
    endcase

    wait_d = (state_q == S_MEM && state_d == S_MEM) ? wait_q + WCW'(1) : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_RST;
      ctrl_q    <= CTRL_IDLE;
      alufunc_q <= '0;
      wait_q    <= '0;
      ld_q      <= 1'b0;
      st_q      <= 1'b0;
      br_q      <= 1'b0;
      nop_q     <= 1'b0;
      cond_q    <= COND_PL;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      alufunc_q <= alufunc_d;
      wait_q    <= wait_d;
      if (state_q == S_ID) begin
        ld_q   <= dec_ld;
        st_q   <= dec_st;
        br_q   <= dec_br;
        nop_q  <= dec_illegal;
        cond_q <= dec_cond;
      end
    end
  end

`ifdef KGP_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (reset)                  illegal_q <= 1'b0;
    else if (state_d == S_HALT) illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign readim    = ctrl_q.readim;
  assign ldir      = ctrl_q.ldir;
  assign ldnpc     = ctrl_q.ldnpc;
  assign ldA       = ctrl_q.lda;
  assign ldB       = ctrl_q.ldb;
  assign ldimm     = ctrl_q.ldimm;
  assign cond_sel  = ctrl_q.cond_sel;
  assign opcond    = ctrl_q.opcond;
  assign alusel1   = ctrl_q.alusel1;
  assign alusel2   = ctrl_q.alusel2;
  assign aluen     = ctrl_q.aluen;
  assign ldaluout  = ctrl_q.ldaluout;
  assign alufunc   = alufunc_q;
  assign writedmem = ctrl_q.writedmem;
  assign readdmem  = ctrl_q.readdmem;
  assign ldlmd     = ctrl_q.ldlmd;
  assign selwb     = ctrl_q.selwb;
  assign regwrite  = ctrl_q.regwrite;
  assign branch    = ctrl_q.branch;
  assign ldpc      = ctrl_q.ldpc;
  assign mem_err   = ctrl_q.mem_err;

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Directed bench for kgp_multicycle_ctrl: per-cycle comparison of every output against hand-built vectors.
// Expectations for the illegal opcode follow KGP_CTRL_ILLEGAL_TRAP_EN when it is defined.
module tb_kgp_multicycle_ctrl;

  typedef struct packed {
    logic       readim, ldir, ldnpc, lda, ldb, ldimm;
    logic [1:0] cond_sel;
    logic       opcond, alusel1, alusel2, aluen, ldaluout;
    logic [3:0] alufunc;
    logic       writedmem, readdmem, ldlmd;
    logic       selwb, regwrite, branch, ldpc, mem_err, illegal;
  } outs_t;

  logic        clk;
  logic        reset;
  logic [31:0] irout;
  logic        dmem_ready;
  logic        readim, ldir, ldnpc, ldA, ldB, ldimm;
  logic [1:0]  cond_sel;
  logic        opcond, alusel1, alusel2, aluen, ldaluout;
  logic [3:0]  alufunc;
  logic        writedmem, readdmem, ldlmd;
  logic        selwb, regwrite, branch, ldpc, mem_err, illegal;
  outs_t       obs;

  int checks = 0;
  int errors = 0;

  kgp_multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .irout      (irout),
    .dmem_ready (dmem_ready),
    .readim     (readim),
    .ldir       (ldir),
    .ldnpc      (ldnpc),
    .ldA        (ldA),
    .ldB        (ldB),
    .ldimm      (ldimm),
    .cond_sel   (cond_sel),
    .opcond     (opcond),
    .alusel1    (alusel1),
    .alusel2    (alusel2),
    .aluen      (aluen),
    .ldaluout   (ldaluout),
    .alufunc    (alufunc),
    .writedmem  (writedmem),
    .readdmem   (readdmem),
    .ldlmd      (ldlmd),
    .selwb      (selwb),
    .regwrite   (regwrite),
    .branch     (branch),
    .ldpc       (ldpc),
    .mem_err    (mem_err),
    .illegal    (illegal)
  );

  assign obs = {readim, ldir, ldnpc, ldA, ldB, ldimm, cond_sel, opcond, alusel1, alusel2,
                aluen, ldaluout, alufunc, writedmem, readdmem, ldlmd,
                selwb, regwrite, branch, ldpc, mem_err, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %07h expected %07h", tag, got, exp);
    end
  endtask

  function automatic outs_t o_if();
    outs_t o = '0;
    o.readim = 1'b1; o.ldir = 1'b1; o.ldnpc = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_id();
    outs_t o = '0;
    o.lda = 1'b1; o.ldb = 1'b1; o.ldimm = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_ex(input logic s1, input logic s2, input logic [3:0] fn, input logic oc);
    outs_t o = '0;
    o.aluen = 1'b1; o.ldaluout = 1'b1;
    o.alusel1 = s1; o.alusel2 = s2; o.alufunc = fn; o.opcond = oc;
    return o;
  endfunction

  function automatic outs_t o_mem(input logic rd, input logic wr);
    outs_t o = '0;
    o.readdmem = rd; o.writedmem = wr;
    return o;
  endfunction

  function automatic outs_t o_wb(input logic rw, input logic sel, input logic lmd,
                                 input logic br, input logic [1:0] cond, input logic err);
    outs_t o = '0;
    o.ldpc = 1'b1; o.regwrite = rw; o.selwb = sel; o.ldlmd = lmd;
    o.branch = br; o.cond_sel = cond; o.mem_err = err;
    return o;
  endfunction

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [5:0] fn);
    return {op, 20'd0, fn};
  endfunction

  // Advance one clock and compare all outputs 1 ns after the rising edge.
  task automatic cyc(input string tag, input outs_t exp);
    @(posedge clk);
    #1;
    check(tag, 32'(obs), 32'(exp));
  endtask

  task automatic run_alu(input string t, input logic [5:0] op, input logic [5:0] fn,
                         input logic s2, input logic [3:0] afn);
    irout = ins(op, fn);
    cyc({t, "_if"}, o_if());
    cyc({t, "_id"}, o_id());
    cyc({t, "_ex"}, o_ex(1'b1, s2, afn, 1'b0));
    cyc({t, "_wb"}, o_wb(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
  endtask

  task automatic run_branch(input string t, input logic [5:0] op, input logic [1:0] cond);
    irout = ins(op, 6'd0);
    cyc({t, "_if"}, o_if());
    cyc({t, "_id"}, o_id());
    cyc({t, "_ex"}, o_ex(1'b0, 1'b1, 4'd10, 1'b1));
    cyc({t, "_wb"}, o_wb(1'b0, 1'b0, 1'b0, 1'b1, cond, 1'b0));
  endtask

  initial begin
    reset      = 1'b1;
    irout      = '0;
    dmem_ready = 1'b0;

    for (int i = 0; i < 3; i++) cyc("reset_hold", '0);
    reset = 1'b0;

    run_alu("add",  6'h00, 6'd1,  1'b0, 4'd0);
    run_alu("addi", 6'h10, 6'd0,  1'b1, 4'd0);
    run_alu("srli", 6'h19, 6'd0,  1'b1, 4'd9);
    run_alu("srl",  6'h00, 6'd10, 1'b0, 4'd9);
    run_alu("move", 6'h1A, 6'd0,  1'b1, 4'd0);

    // LD: three wait cycles, ready on the fourth MEM cycle.
    irout = ins(6'h21, 6'd0);
    cyc("ld_if", o_if());
    cyc("ld_id", o_id());
    cyc("ld_ex", o_ex(1'b1, 1'b1, 4'd0, 1'b0));
    for (int i = 0; i < 4; i++) cyc("ld_mem", o_mem(1'b1, 1'b0));
    dmem_ready = 1'b1;
    cyc("ld_wb", o_wb(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
    dmem_ready = 1'b0;

    // ST with no ready: full timeout window, then a one-cycle error pulse.
    irout = ins(6'h22, 6'd0);
    cyc("st_if", o_if());
    cyc("st_id", o_id());
    cyc("st_ex", o_ex(1'b1, 1'b1, 4'd0, 1'b0));
    for (int i = 0; i < 15; i++) cyc("st_mem", o_mem(1'b0, 1'b1));
    cyc("st_wb_timeout", o_wb(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1));
    cyc("st_err_cleared", o_if());

    irout = ins(6'h33, 6'd0);
    cyc("bz_id", o_id());
    cyc("bz_ex", o_ex(1'b0, 1'b1, 4'd10, 1'b1));
    cyc("bz_wb", o_wb(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0));
    run_branch("bmi", 6'h31, 2'b01);
    run_branch("br",  6'h30, 2'b11);

    // Illegal opcode 0x3F.
    irout = ins(6'h3F, 6'd0);
    cyc("ill_if", o_if());
    cyc("ill_id", o_id());
`ifdef KGP_CTRL_ILLEGAL_TRAP_EN
    begin
      outs_t halt_o;
      halt_o = '0;
      halt_o.illegal = 1'b1;
      for (int i = 0; i < 3; i++) cyc("ill_halt", halt_o);
    end
`else
    cyc("ill_ex_nop", '0);
    cyc("ill_wb_nop", o_wb(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0));
`endif
    reset = 1'b1;
    cyc("ill_reset", '0);
    irout = ins(6'h21, 6'd0);
    reset = 1'b0;

    // LD aborted by reset in the middle of MEM.
    cyc("mid_if", o_if());
    cyc("mid_id", o_id());
    cyc("mid_ex", o_ex(1'b1, 1'b1, 4'd0, 1'b0));
    cyc("mid_mem", o_mem(1'b1, 1'b0));
    cyc("mid_mem", o_mem(1'b1, 1'b0));
    reset = 1'b1;
    cyc("mid_reset", '0);
    reset = 1'b0;

    // LD with immediate ready: minimum five-cycle memory instruction.
    dmem_ready = 1'b1;
    cyc("ld0_if", o_if());
    cyc("ld0_id", o_id());
    cyc("ld0_ex", o_ex(1'b1, 1'b1, 4'd0, 1'b0));
    cyc("ld0_mem", o_mem(1'b1, 1'b0));
    cyc("ld0_wb", o_wb(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0));
    dmem_ready = 1'b0;
    cyc("ld0_next_if", o_if());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
